// File: rtl/mem_store_unit.sv
// ---------------------------------------------------------------------------------------------
// mem_store_unit
//
// Store side of the LC-3b datapath-to-memory interface. Accepts a 16-bit register value and a
// byte address, issues one lane-aligned memory write with byte enables, and waits for mem_resp.
// Byte stores (STB) replicate data[7:0] onto both lanes and enable one lane; word stores
// (STR/STI) write the full word and must be word aligned. A misaligned word store, or a write
// that sees no mem_resp within TIMEOUT cycles, produces a one-cycle error pulse.
//
// Ports
//   clk              in   1   clock, rising edge
//   reset            in   1   synchronous, active-high reset
//   start            in   1   request a store; sampled only in IDLE
//   is_byte          in   1   1 = byte store, 0 = word store
//   addr             in   16  byte address of the store
//   data             in   16  register value; byte store uses data[7:0]
//   busy             out  1   high whenever the unit is not idle
//   done             out  1   one-cycle pulse: store acknowledged by memory
//   error            out  1   one-cycle pulse: misaligned word store or timeout
//   mem_address      out  16  word-aligned address
//   mem_wdata        out  16  lane-placed write data
//   mem_byte_enable  out  2   [1] = high byte, [0] = low byte
//   mem_write        out  1   write strobe, held until mem_resp or timeout
//   mem_resp         in   1   memory acknowledge; only meaningful while writing
// ---------------------------------------------------------------------------------------------
module mem_store_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_byte,
    input  logic [15:0] addr,
    input  logic [15:0] data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_byte_enable,
    output logic        mem_write,
    input  logic        mem_resp
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;
    localparam logic [1:0] StErr   = 2'd3;

    // Counter value on the last permitted write cycle.
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Only the word address is kept; the lane choice is already folded into be_q.
    logic [14:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [1:0]       be_q, be_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = addr[15:1];
                    wdata_d = is_byte ? {data[7:0], data[7:0]} : data;
                    be_d    = is_byte ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
                    cnt_d   = '0;
                    // Misaligned word store never reaches memory.
                    state_d = (!is_byte && addr[0]) ? StErr : StWrite;
                end
            end
            StWrite: begin
                // Acknowledge wins over expiry in the same cycle.
                if (mem_resp) begin
                    state_d = StDone;
                end else if (cnt_q == LastCnt) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);
    assign error           = (state_q == StErr);
    assign mem_write       = (state_q == StWrite);
    assign mem_address     = {addr_q, 1'b0};
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = be_q;

endmodule

// File: tb/tb_mem_store_unit.sv
module tb_mem_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_byte;
    logic [15:0] addr;
    logic [15:0] data;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_write;
    logic        mem_resp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_store_unit #(
        .TIMEOUT(4),
        .CNT_W  (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .is_byte        (is_byte),
        .addr           (addr),
        .data           (data),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_write      (mem_write),
        .mem_resp       (mem_resp)
    );

    typedef struct {
        logic        is_byte;
        logic [15:0] addr;
        logic [15:0] data;
        logic        exp_err;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [1:0]  exp_be;
    } vec_t;

    vec_t vecs[6];

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts one store and follows it until idle. mem_resp is raised during write cycle
    // resp_cycle (0 = never). Counts cycles with mem_write, busy, done and error.
    task automatic run_store(input logic b, input logic [15:0] a, input logic [15:0] d,
                             input int resp_cycle, output int nwr, output int nbusy,
                             output int ndone, output int nerr);
        int c;
        nwr = 0; nbusy = 0; ndone = 0; nerr = 0; c = 1;
        is_byte = b; addr = a; data = d; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_write) nwr++;
            if (busy) nbusy++;
            if (done) ndone++;
            if (error) nerr++;
            if (!busy) break;
            mem_resp = mem_write && (c == resp_cycle);
            tick();
            c++;
        end
        mem_resp = 1'b0;
        check("run_store_ends_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int nwr, nbusy, ndone, nerr;
        logic [4:0] busy_seq;

        vecs[0] = '{1'b0, 16'h3000, 16'hBEEF, 1'b0, 16'h3000, 16'hBEEF, 2'b11};
        vecs[1] = '{1'b1, 16'h3001, 16'h12A5, 1'b0, 16'h3000, 16'hA5A5, 2'b10};
        vecs[2] = '{1'b1, 16'h3000, 16'h12A5, 1'b0, 16'h3000, 16'hA5A5, 2'b01};
        vecs[3] = '{1'b0, 16'h3003, 16'h5555, 1'b1, 16'h0000, 16'h0000, 2'b00};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h00FF, 1'b0, 16'hFFFE, 16'hFFFF, 2'b10};
        vecs[5] = '{1'b0, 16'h0000, 16'h1234, 1'b0, 16'h0000, 16'h1234, 2'b11};

        reset = 1'b1; start = 1'b0; is_byte = 1'b0; addr = '0; data = '0; mem_resp = 1'b0;
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_mem_write", {31'd0, mem_write}, 32'd0);
        check("reset_mem_address", {16'd0, mem_address}, 32'd0);
        check("reset_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("reset_be", {30'd0, mem_byte_enable}, 32'd0);
        reset = 1'b0;
        tick();

        // Table: one store per vector, immediate acknowledge.
        for (int i = 0; i < 6; i++) begin
            is_byte = vecs[i].is_byte; addr = vecs[i].addr; data = vecs[i].data;
            start = 1'b1;
            tick();
            start = 1'b0;
            check("vec_busy", {31'd0, busy}, 32'd1);
            if (vecs[i].exp_err) begin
                check("vec_err_pulse", {31'd0, error}, 32'd1);
                check("vec_err_no_write", {31'd0, mem_write}, 32'd0);
                tick();
                check("vec_err_cleared", {31'd0, error}, 32'd0);
            end else begin
                check("vec_mem_write", {31'd0, mem_write}, 32'd1);
                check("vec_mem_address", {16'd0, mem_address}, {16'd0, vecs[i].exp_addr});
                check("vec_mem_wdata", {16'd0, mem_wdata}, {16'd0, vecs[i].exp_wdata});
                check("vec_be", {30'd0, mem_byte_enable}, {30'd0, vecs[i].exp_be});
                mem_resp = 1'b1;
                tick();
                mem_resp = 1'b0;
                check("vec_done", {31'd0, done}, 32'd1);
                check("vec_done_no_write", {31'd0, mem_write}, 32'd0);
                tick();
                check("vec_done_cleared", {31'd0, done}, 32'd0);
            end
            check("vec_idle", {31'd0, busy}, 32'd0);
        end

        // Word store acknowledged on third write cycle.
        run_store(1'b0, 16'h3000, 16'hBEEF, 3, nwr, nbusy, ndone, nerr);
        check("resp3_writes", nwr, 3);
        check("resp3_done", ndone, 1);
        check("resp3_err", nerr, 0);

        // Misaligned word store.
        run_store(1'b0, 16'h3003, 16'hBEEF, 0, nwr, nbusy, ndone, nerr);
        check("misalign_writes", nwr, 0);
        check("misalign_busy", nbusy, 1);
        check("misalign_err", nerr, 1);
        check("misalign_done", ndone, 0);

        // Timeout with no acknowledge.
        run_store(1'b1, 16'h4001, 16'h0077, 0, nwr, nbusy, ndone, nerr);
        check("timeout_writes", nwr, 4);
        check("timeout_err", nerr, 1);
        check("timeout_done", ndone, 0);

        // Acknowledge on the last permitted cycle wins over expiry.
        run_store(1'b0, 16'h4000, 16'h0077, 4, nwr, nbusy, ndone, nerr);
        check("lastcyc_writes", nwr, 4);
        check("lastcyc_done", ndone, 1);
        check("lastcyc_err", nerr, 0);

        // Reset while writing.
        is_byte = 1'b0; addr = 16'h5000; data = 16'hCAFE; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rst_pre_write", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        tick();
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        check("late_resp_busy", {31'd0, busy}, 32'd0);
        check("late_resp_done", {31'd0, done}, 32'd0);
        run_store(1'b0, 16'h5000, 16'hCAFE, 2, nwr, nbusy, ndone, nerr);
        check("post_rst_writes", nwr, 2);
        check("post_rst_done", ndone, 1);

        // start held high with immediate acknowledge: WRITE, DONE, IDLE, WRITE, DONE.
        nwr = 0; ndone = 0;
        is_byte = 1'b0; addr = 16'h6000; data = 16'h1111;
        start = 1'b1; mem_resp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            busy_seq[i] = busy;
            if (mem_write) nwr++;
            if (done) ndone++;
        end
        start = 1'b0; mem_resp = 1'b0;
        tick();
        if (done) ndone++;
        check("b2b_busy_seq", {27'd0, busy_seq}, 32'b11011);
        check("b2b_writes", nwr, 2);
        check("b2b_done", ndone, 2);
        check("b2b_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
